// File: rtl/veggie_fb_pkg.sv
// Shared frame-buffer geometry and types for the frame writer and frame displayer.
package veggie_fb_pkg;
   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;
   localparam int FB_DEPTH  = 307200;
   localparam int FB_ADDR_W = 19;
   localparam int COLOR_W   = 8;
   localparam int COORD_W   = 10;

   typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} fwa_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   always_comb begin
      int               w_j;
      logic [IDX_W-1:0] w_j_idx;
      w_j     = 0;
      w_j_idx = '0;
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         w_j = int'(i_ptr) + k;
         if (w_j >= N) w_j = w_j - N;
         w_j_idx = IDX_W'(w_j);
         if (!o_valid && i_req[w_j_idx]) begin
            o_valid        = 1'b1;
            o_gnt[w_j_idx] = 1'b1;
            o_idx          = w_j_idx;
         end
      end
   end

endmodule

// File: rtl/frame_write_arbiter.sv
// Owns the frame-buffer write port: round-robin pixel writers plus a full-frame clear engine.
module frame_write_arbiter
   import veggie_fb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*COORD_W-1:0]   req_x,
   input  logic [N_REQ*COORD_W-1:0]   req_y,
   input  logic [N_REQ*COLOR_W-1:0]   req_color,
   output logic [N_REQ-1:0]           gnt,
   input  logic                       clear_start,
   input  logic [COLOR_W-1:0]         clear_color,
   output logic                       clear_busy,
   output logic                       drop,
   output logic [FB_ADDR_W-1:0]       frame_wraddress,
   output logic [COLOR_W-1:0]         frame_data,
   output logic                       frame_we
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW1   = COORD_W + 1;
   localparam logic [CW1-1:0]       X_LIM     = CW1'(H_RES);
   localparam logic [CW1-1:0]       Y_LIM     = CW1'(V_RES);
   localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(H_RES * V_RES - 1);

   fwa_state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]       r_ptr;
   logic [FB_ADDR_W-1:0]   r_cnt;
   logic [COLOR_W-1:0]     r_clear_color;
   logic                   r_we, r_drop;
   logic [FB_ADDR_W-1:0]   r_addr;
   logic [COLOR_W-1:0]     r_data;

   logic [N_REQ-1:0]       w_gnt;
   logic [IDX_W-1:0]       w_idx;
   logic                   w_valid;
   logic                   w_arb_en, w_clear_go, w_grant_fire;
   logic [COORD_W-1:0]     w_sel_x, w_sel_y;
   logic [COLOR_W-1:0]     w_sel_color;
   logic [FB_ADDR_W-1:0]   w_x_ext, w_y_ext, w_addr;
   logic                   w_in_range;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_gnt),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   // clear_start wins over pending requests; reset also masks any grant.
   always_comb begin
      w_state_nxt = r_state;
      w_arb_en    = 1'b0;
      w_clear_go  = 1'b0;
      case (r_state)
         ARB: begin
            if (clear_start) begin
               w_clear_go  = 1'b1;
               w_state_nxt = CLEAR;
            end else begin
               w_arb_en = !Reset;
            end
         end
         CLEAR: begin
            if (r_cnt == LAST_ADDR) w_state_nxt = ARB;
         end
         default: w_state_nxt = ARB;
      endcase
   end

   assign gnt          = w_arb_en ? w_gnt : '0;
   assign w_grant_fire = w_arb_en && w_valid;

   always_comb begin
      w_sel_x     = '0;
      w_sel_y     = '0;
      w_sel_color = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_gnt[i]) begin
            w_sel_x     = req_x[i*COORD_W +: COORD_W];
            w_sel_y     = req_y[i*COORD_W +: COORD_W];
            w_sel_color = req_color[i*COLOR_W +: COLOR_W];
         end
      end
   end

   assign w_x_ext    = {{(FB_ADDR_W-COORD_W){1'b0}}, w_sel_x};
   assign w_y_ext    = {{(FB_ADDR_W-COORD_W){1'b0}}, w_sel_y};
   assign w_in_range = ({1'b0, w_sel_x} < X_LIM) && ({1'b0, w_sel_y} < Y_LIM);

   // 640 = 512 + 128, so the row offset needs no multiplier.
   generate
      if (H_RES == 640) begin : g_shift_add
         assign w_addr = (w_y_ext << 9) + (w_y_ext << 7) + w_x_ext;
      end else begin : g_mul
         assign w_addr = w_y_ext * FB_ADDR_W'(H_RES) + w_x_ext;
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state       <= ARB;
         r_ptr         <= '0;
         r_cnt         <= '0;
         r_clear_color <= '0;
         r_we          <= 1'b0;
         r_drop        <= 1'b0;
         r_addr        <= '0;
         r_data        <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_we    <= 1'b0;
         r_drop  <= 1'b0;
         if (w_clear_go) begin
            r_cnt         <= '0;
            r_clear_color <= clear_color;
         end else if (r_state == CLEAR) begin
            r_we   <= 1'b1;
            r_addr <= r_cnt;
            r_data <= r_clear_color;
            r_cnt  <= r_cnt + 1'b1;
         end else if (w_grant_fire) begin
            r_ptr <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            if (w_in_range) begin
               r_we   <= 1'b1;
               r_addr <= w_addr;
               r_data <= w_sel_color;
            end else begin
               r_drop <= 1'b1;
            end
         end
      end
   end

   assign clear_busy      = (r_state == CLEAR);
   assign drop            = r_drop;
   assign frame_we        = r_we;
   assign frame_wraddress = r_addr;
   assign frame_data      = r_data;

endmodule
